// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser state encoding, frame constants and the
// baud divisor helper used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    function automatic int baud_div(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser. A start pulse loads a byte; done pulses in the last
// cycle of the stop bit so a new start can follow with no idle gap.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 20833
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       done,
    output logic       txd
);

    localparam int               CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("uart_byte_tx: BAUD_DIV must be at least 2");
    end
    if (UART_STOP_BITS != 1) begin : g_bad_stop
        $error("uart_byte_tx: only one stop bit is supported");
    end

    uart_tx_state_t   state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             baud_end;

    assign baud_end = (baud_q == BAUD_LAST);
    assign done     = (state_q == STOP) && baud_end;
    assign txd      = txd_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (start) begin
                    state_d = START;
                    shift_d = byte_in;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chaining straight into the next start bit keeps a word gap-free.
                    if (start) begin
                        state_d = START;
                        shift_d = byte_in;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// Word-wide UART transmitter: latches a word at the valid/ready handshake and
// sends it as consecutive 8N1 bytes, least-significant byte first.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 200000000,
    parameter int UART_BPS   = 9600,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [DATA_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  uart_txd,
    output logic                  busy
);

    localparam int              BAUD_DIV  = baud_div(CLK_FREQ, UART_BPS);
    localparam int              NUM_BYTES = DATA_WIDTH / 8;
    localparam int              BC_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BC_W-1:0] BC_LAST   = BC_W'(NUM_BYTES - 1);

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
        $error("uart_word_tx: DATA_WIDTH must be a non-zero multiple of 8");
    end

    typedef enum logic {
        WORD_IDLE,
        WORD_SEND
    } word_state_t;

    word_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BC_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  handshake;
    logic                  last_byte;
    logic                  byte_done;
    logic                  byte_start;
    logic [7:0]            byte_in;

    assign word_ready = (state_q == WORD_IDLE) && !sys_rst;
    assign handshake  = word_valid && word_ready;
    assign shifted    = shift_q >> 8;
    assign last_byte  = (byte_cnt_q == BC_LAST);
    assign busy       = busy_q;

    // The serialiser loads its byte on the same edge the word register updates,
    // so it is fed the value that register is about to take.
    assign byte_start = handshake || ((state_q == WORD_SEND) && byte_done && !last_byte);
    assign byte_in    = handshake ? word_data[7:0] : shifted[7:0];

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        busy_d     = busy_q;
        case (state_q)
            WORD_IDLE: begin
                if (handshake) begin
                    state_d    = WORD_SEND;
                    shift_d    = word_data;
                    byte_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end
            WORD_SEND: begin
                if (byte_done) begin
                    if (last_byte) begin
                        state_d = WORD_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        shift_d    = shifted;
                    end
                end
            end
            default: state_d = WORD_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= WORD_IDLE;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            busy_q     <= busy_d;
        end
    end

    uart_byte_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte_tx (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (byte_start),
        .byte_in (byte_in),
        .done    (byte_done),
        .txd     (uart_txd)
    );

endmodule

// File: tb/tb_uart_word_tx.sv
// Randomised scoreboard bench: the driver queues expected words with their
// predicted start edge, and a line monitor decodes the serial output against them.
module tb_uart_word_tx;

    localparam int CLK_FREQ = 1000;
    localparam int UART_BPS = 100;
    localparam int B        = 10;
    localparam int WORD_CYC = 4 * 10 * B;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [31:0] data_a;
    logic        valid_a, ready_a, txd_a, busy_a;
    logic [7:0]  data_b;
    logic        valid_b, ready_b, txd_b, busy_b;

    always #5 clk = ~clk;

    uart_word_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .UART_BPS  (UART_BPS),
        .DATA_WIDTH(32)
    ) u_dut_a (
        .sys_clk   (clk),
        .sys_rst   (sys_rst),
        .word_data (data_a),
        .word_valid(valid_a),
        .word_ready(ready_a),
        .uart_txd  (txd_a),
        .busy      (busy_a)
    );

    uart_word_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .UART_BPS  (UART_BPS),
        .DATA_WIDTH(8)
    ) u_dut_b (
        .sys_clk   (clk),
        .sys_rst   (sys_rst),
        .word_data (data_b),
        .word_valid(valid_b),
        .word_ready(ready_b),
        .uart_txd  (txd_b),
        .busy      (busy_b)
    );

    typedef struct {
        logic [31:0] word;
        int          t_edge;
    } item_t;

    item_t exp_q[$];
    int    cyc          = 0;
    int    hs_count     = 0;
    int    checks       = 0;
    int    errors       = 0;
    int    aborted      = 0;
    int    words_issued = 0;
    int    t_free       = 0;
    bit    mon_active   = 1'b0;
    bit    line_prev    = 1'b1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (valid_a === 1'b1 && ready_a === 1'b1)
            hs_count <= hs_count + 1;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise valid once the model says the DUT is idle (plus gap cycles); the
    // handshake lands on the very next edge.
    task automatic send_a(input logic [31:0] w, input int gap, input bit keep, output int t);
        while (cyc < t_free + gap) tick(1);
        data_a  = w;
        valid_a = 1'b1;
        t       = cyc + 1;
        exp_q.push_back('{w, t});
        words_issued++;
        tick(1);
        if (keep) data_a = $urandom;
        else      valid_a = 1'b0;
        t_free = t + WORD_CYC;
    endtask

    task automatic mon_word(input item_t it);
        logic [7:0] eb, rx;
        int         lvl_err, hs_err;
        logic       exp_bit;
        mon_active = 1'b1;
        chk("start_edge", 64'(cyc), 64'(it.t_edge));
        for (int b = 0; b < 4; b++) begin
            eb      = it.word[8*b +: 8];
            rx      = '0;
            lvl_err = 0;
            hs_err  = 0;
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < B; c++) begin
                    if (!(b == 0 && k == 0 && c == 0)) @(negedge clk);
                    if (sys_rst === 1'b1) begin
                        aborted++;
                        mon_active = 1'b0;
                        return;
                    end
                    exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : eb[k-1];
                    if (txd_a !== exp_bit) lvl_err++;
                    if (c == B / 2 && k >= 1 && k <= 8) rx[k-1] = txd_a;
                    if (busy_a !== 1'b1 || ready_a !== 1'b0) hs_err++;
                end
            end
            chk($sformatf("byte%0d_value", b), 64'(rx), 64'(eb));
            chk($sformatf("byte%0d_bit_timing", b), 64'(lvl_err), 64'd0);
            chk($sformatf("byte%0d_busy_ready", b), 64'(hs_err), 64'd0);
        end
        @(negedge clk);
        if (sys_rst === 1'b1) begin
            aborted++;
            mon_active = 1'b0;
            return;
        end
        chk("word_end_txd_busy_ready", 64'({txd_a, busy_a, ready_a}), 64'(3'b101));
        mon_active = 1'b0;
    endtask

    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (sys_rst !== 1'b0) begin
                line_prev = 1'b1;
            end else if (line_prev && txd_a === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame_pending_words", 64'(exp_q.size()), 64'd1);
                end else begin
                    it = exp_q.pop_front();
                    mon_word(it);
                end
            end
            line_prev = (txd_a === 1'b1);
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          t, t1, t2, n, quiet_err, b_lvl, b_busy;
        int          gaps[7];
        logic [9:0]  frame;
        logic [7:0]  wb;

        sys_rst = 1'b1;
        valid_a = 1'b0;
        data_a  = '0;
        valid_b = 1'b0;
        data_b  = '0;

        // Reset: idle line, not busy, not ready while reset is high.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_txd_busy_ready", 64'({txd_a, busy_a, ready_a}), 64'(3'b100));
        end
        sys_rst = 1'b0;
        @(negedge clk);
        chk("post_reset_txd_busy_ready", 64'({txd_a, busy_a, ready_a}), 64'(3'b101));
        chk("post_reset_b_txd_busy_ready", 64'({txd_b, busy_b, ready_b}), 64'(3'b101));
        @(posedge clk);
        #1;
        t_free = cyc;

        // Single word.
        send_a(32'hA5C3_0F81, 0, 1'b0, t);

        // Back-to-back with valid held high.
        send_a(32'h0000_00FF, 2, 1'b1, t1);
        send_a(32'hFFFF_FF00, 0, 1'b0, t2);

        // Input changes during byte 1 must be ignored.
        send_a(32'h3C96_E17B, 2, 1'b0, t);
        while (cyc < t + 150) tick(1);
        data_a  = $urandom;
        valid_a = 1'b1;
        tick(5);
        valid_a = 1'b0;

        // One-cycle reset during a data bit of byte 2.
        send_a(32'hDEAD_BEEF, 2, 1'b0, t);
        while (cyc < t + 234) tick(1);
        sys_rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready_low", 64'(ready_a), 64'd0);
        @(posedge clk);
        #1;
        sys_rst = 1'b0;
        t_free  = cyc;
        @(negedge clk);
        chk("midrst_txd_busy_ready", 64'({txd_a, busy_a, ready_a}), 64'(3'b101));
        quiet_err = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (txd_a !== 1'b1 || busy_a !== 1'b0) quiet_err++;
        end
        chk("midrst_line_quiet", 64'(quiet_err), 64'd0);
        @(posedge clk);
        #1;
        send_a(32'h1234_5678, 1, 1'b0, t);

        // Random words with random gaps; gap 0 after a held valid is back-to-back.
        for (int i = 0; i < 7; i++)
            gaps[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
        for (int i = 0; i < 6; i++)
            send_a($urandom, gaps[i], (i < 5) && (gaps[i+1] == 0), t);

        n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("scoreboard_drain", 64'(exp_q.size() + int'(mon_active)), 64'd0);
        chk("handshake_count", 64'(hs_count), 64'(words_issued));
        chk("aborted_words", 64'(aborted), 64'd1);

        // Byte-wide variant: exactly one frame.
        wb     = 8'h55;
        frame  = {1'b1, wb, 1'b0};
        data_b = wb;
        valid_b = 1'b1;
        @(posedge clk);
        #1;
        valid_b = 1'b0;
        data_b  = 8'hAA;
        b_busy  = 0;
        for (int k = 0; k < 10; k++) begin
            b_lvl = 0;
            for (int c = 0; c < B; c++) begin
                @(negedge clk);
                if (txd_b !== frame[k]) b_lvl++;
                if (busy_b !== 1'b1) b_busy++;
            end
            chk($sformatf("w8_bit%0d_errors", k), 64'(b_lvl), 64'd0);
        end
        chk("w8_busy_errors", 64'(b_busy), 64'd0);
        @(negedge clk);
        chk("w8_end_txd_busy_ready", 64'({txd_b, busy_b, ready_b}), 64'(3'b101));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Transmit-side companion to the UART receive path: accepts `DATA_WIDTH`-bit words over a valid/ready handshake and serialises each word onto `uart_txd` as consecutive 8N1 bytes, least-significant byte first. It sits between the word FIFO and the board TX pin, alongside the receiver, in the board-level top. It runs at the system clock frequency, and its baud rate is derived from parameters.

## Interface
Parameters:
- `CLK_FREQ`, default 200000000: `sys_clk` frequency in Hz.
- `UART_BPS`, default 9600: line baud rate.
- `DATA_WIDTH`, default 32: word width. Must be a multiple of 8. Elaboration error otherwise.
- Derived `BAUD_DIV = CLK_FREQ / UART_BPS` (integer division; 20833 at defaults). Elaboration error if `BAUD_DIV < 2`.
- Derived `NUM_BYTES = DATA_WIDTH / 8`.

Ports:
- `sys_clk`, input, 1: the single clock.
- `sys_rst`, input, 1: synchronous, active-high reset.
- `word_data`, input, `DATA_WIDTH`: word to send. Sampled only at the handshake.
- `word_valid`, input, 1: the producer has a word.
- `word_ready`, output, 1: the block can accept a word.
- `uart_txd`, output, 1: serial line. Idles high. Registered.
- `busy`, output, 1: a word is in flight. Registered.

## Operation
- State machine: IDLE, START, DATA, STOP.
- IDLE:
  - `word_ready` = 1 and `uart_txd` = 1.
  - On `word_valid & word_ready`, the block latches `word_data` into a shift register, clears the byte counter, and moves to START.
- START: `uart_txd` = 0 for `BAUD_DIV` cycles, then DATA.
- DATA:
  - Sends 8 bits, LSB first. Each bit is held `BAUD_DIV` cycles.
  - The bit counter runs 0..7, then the state moves to STOP.
- STOP: `uart_txd` = 1 for `BAUD_DIV` cycles. At the end of STOP:
  - If the byte counter is `NUM_BYTES-1`, go to IDLE.
  - Otherwise, increment the byte counter, shift the word right by 8, and go to START. There is no idle gap between bytes of one word.
- Baud counter:
  - Counts 0..`BAUD_DIV-1`.
  - Clears on every state change and at every bit boundary.
  - Width is `$clog2(BAUD_DIV)`.
- `word_ready` = (state == IDLE) & ~`sys_rst`.
- `busy` = (state != IDLE).
- While busy, changes on `word_data` and `word_valid` are ignored. The latched word is not affected.
- Reset, including in the middle of a frame:
  - On the next `sys_clk` edge: state IDLE, `uart_txd` = 1, `busy` = 0, all counters 0.
  - The in-flight word is discarded, not retransmitted.
  - `word_ready` is 0 during every cycle `sys_rst` is high.

## Timing
- Reset values: `uart_txd` = 1, `busy` = 0, `word_ready` = 1 in the first cycle after `sys_rst` deasserts.
- Handshake at edge T:
  - `uart_txd` falls and `busy` rises immediately after edge T. Latency is one edge.
  - `word_ready` falls in the same cycle.
- Bit k of the frame (0 = start, 1..8 = data, 9 = stop) occupies cycles [T + k·`BAUD_DIV`, T + (k+1)·`BAUD_DIV`).
- One byte frame = 10·`BAUD_DIV` cycles. One word = `NUM_BYTES`·10·`BAUD_DIV` cycles.
- The return to IDLE occurs at edge T + 40·`BAUD_DIV` at defaults. `word_ready` and `busy` update at that edge.
- Back-to-back words with `word_valid` held high:
  - The next handshake is at edge T + 40·`BAUD_DIV` + 1.
  - Between words, the line is high for exactly `BAUD_DIV` + 1 cycles: the stop bit plus one idle cycle.

## Structure
- Shared package `uart_pkg`:
  - State enum `uart_tx_state_t` (IDLE, START, DATA, STOP).
  - Function `baud_div(clk_freq, bps)`, also used by the receiver.
  - Constants `UART_DATA_BITS = 8` and `UART_STOP_BITS = 1`.
- One sub-module, `uart_byte_tx`:
  - 8N1 byte serialiser with a `start`/`done` pulse interface and `BAUD_DIV` as a parameter.
  - `uart_word_tx` wraps it with the word latch, byte counter and handshake.
  - The four states live in `uart_byte_tx`. The wrapper has a two-state IDLE/SEND controller.

## Test plan
Simulation uses `CLK_FREQ` = 1000 and `UART_BPS` = 100, so `BAUD_DIV` = 10.
1. Reset idle: hold `sys_rst` for 5 cycles, then release.
   - `uart_txd` = 1, `busy` = 0 throughout.
   - `word_ready` = 0 during reset and 1 on the first cycle after.
2. Single word 32'hA5C3_0F81:
   - Decode bytes 0x81, 0x0F, 0xC3, 0xA5 in order.
   - Each bit is exactly 10 cycles. The start bit of byte 0 begins 1 edge after the handshake.
   - `busy` is high for 400 cycles.
3. Back-to-back: 32'h0000_00FF then 32'hFFFF_FF00 with `word_valid` held high.
   - Second handshake at edge T + 401.
   - Line high for 11 cycles between the last stop bit's start and the next start bit.
4. Ignore-while-busy: change `word_data` and pulse `word_valid` during byte 1.
   - The transmitted bytes are unchanged.
   - No extra handshake occurs (`word_ready` = 0).
5. Mid-frame reset: assert `sys_rst` for 1 cycle during a data bit of byte 2.
   - `uart_txd` = 1 and `busy` = 0 after the next edge.
   - No further transitions.
   - A new word 32'h1234_5678 is then sent correctly.
6. Width variant: `DATA_WIDTH` = 8, word 8'h55.
   - Exactly one frame: 0, 1,0,1,0,1,0,1,0, then 1.
   - `busy` is high for 100 cycles.
